// File: rtl/sdram_port_arbiter_if.sv
// Bundle between the requesters, the port arbiter and the SDRAM controller command port.
// Handshake: a requester holds p_rd/p_wr until its 1-cycle p_ack; the arbiter holds m_rd/m_wr until m_rdy, then drops them next cycle.
interface sdram_port_arbiter_if #(
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_WIDTH = 25,
  parameter int DATA_WIDTH = 32,
  parameter int WORD_LEN   = 4
);
  logic [NUM_PORTS-1:0]            p_rd;
  logic [NUM_PORTS*WORD_LEN-1:0]   p_wr;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] p_addr;
  logic [NUM_PORTS*DATA_WIDTH-1:0] p_wdata;
  logic [NUM_PORTS-1:0]            p_ack;
  logic [NUM_PORTS-1:0]            p_rvalid;
  logic [NUM_PORTS-1:0]            p_wvalid;
  logic [NUM_PORTS-1:0]            p_err;
  logic [DATA_WIDTH-1:0]           p_rdata;
  logic                            m_rdy;
  logic                            m_rd;
  logic [WORD_LEN-1:0]             m_wr;
  logic [ADDR_WIDTH-1:0]           m_addr;
  logic [DATA_WIDTH-1:0]           m_wdata;
  logic [DATA_WIDTH-1:0]           m_rdata;
  logic                            m_rvalid;
  logic                            m_wvalid;

  modport master (
    input  p_rd, p_wr, p_addr, p_wdata, m_rdy, m_rdata, m_rvalid, m_wvalid,
    output p_ack, p_rvalid, p_wvalid, p_err, p_rdata, m_rd, m_wr, m_addr, m_wdata
  );

  modport slave (
    output p_rd, p_wr, p_addr, p_wdata, m_rdy, m_rdata, m_rvalid, m_wvalid,
    input  p_ack, p_rvalid, p_wvalid, p_err, p_rdata, m_rd, m_wr, m_addr, m_wdata
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Round-robin sharing of one SDRAM controller command port among NUM_PORTS requesters,
// one transaction in flight, completions routed back to the owner, watchdog abort.
module sdram_port_arbiter #(
  parameter int NUM_PORTS      = 4,
  parameter int ADDR_WIDTH     = 25,
  parameter int DATA_WIDTH     = 32,
  parameter int WORD_LEN       = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                clk,
  input  logic                rst,
  sdram_port_arbiter_if.master bus,
  output logic [1:0]          dbg_state
);
  localparam int GW = $clog2(NUM_PORTS);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  logic [1:0]            state;
  logic [GW-1:0]         grant;
  logic [GW-1:0]         last_grant;
  logic [CW-1:0]         cnt;
  logic                  rd_q;
  logic [WORD_LEN-1:0]   wr_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic [NUM_PORTS-1:0]  req;
  logic                  found;
  logic [GW-1:0]         pick;
  logic [GW-1:0]         cand;
  logic                  sel_rd;
  logic [WORD_LEN-1:0]   sel_wr;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  logic accept;
  logic done_r;
  logic done_w;
  logic expire;

  always_comb begin
    req = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      req[i] = bus.p_rd[i] | (|bus.p_wr[i*WORD_LEN +: WORD_LEN]);
  end

  // Search starts just past the last completed owner, so the previous winner ranks last.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      cand = GW'((int'(last_grant) + k) % NUM_PORTS);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    sel_rd    = 1'b0;
    sel_wr    = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (GW'(i) == pick) begin
        sel_rd    = bus.p_rd[i];
        sel_wr    = bus.p_wr[i*WORD_LEN +: WORD_LEN];
        sel_addr  = bus.p_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = bus.p_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign accept = (state == ST_ISSUE) && bus.m_rdy;
  assign done_r = (state == ST_WAIT) && bus.m_rvalid;
  assign done_w = (state == ST_WAIT) && bus.m_wvalid && !bus.m_rvalid;
  assign expire = (state == ST_WAIT) && !bus.m_rvalid && !bus.m_wvalid && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      grant      <= '0;
      last_grant <= GW'(NUM_PORTS - 1);
      cnt        <= '0;
      rd_q       <= 1'b0;
      wr_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (found) begin
            grant   <= pick;
            rd_q    <= sel_rd;
            wr_q    <= sel_rd ? '0 : sel_wr;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (bus.m_rdy) begin
            cnt   <= '0;
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt <= cnt + 1'b1;
          if (done_r || done_w || expire) begin
            last_grant <= grant;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Pulses are gated by rst so a completion arriving during reset is dropped.
  always_comb begin
    bus.p_ack    = '0;
    bus.p_rvalid = '0;
    bus.p_wvalid = '0;
    bus.p_err    = '0;
    if (!rst) begin
      bus.p_ack[grant]    = accept;
      bus.p_rvalid[grant] = done_r;
      bus.p_wvalid[grant] = done_w;
      bus.p_err[grant]    = expire;
    end
  end

  assign bus.m_rd    = !rst && (state == ST_ISSUE) && rd_q;
  assign bus.m_wr    = (!rst && (state == ST_ISSUE)) ? wr_q : '0;
  assign bus.m_addr  = addr_q;
  assign bus.m_wdata = wdata_q;
  assign bus.p_rdata = bus.m_rdata;
  assign dbg_state   = state;
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: drivers push cycle-stamped expected events,
// a negedge monitor pops and compares every pulse the arbiter produces.
module tb_sdram_port_arbiter;
  localparam int NP = 4;
  localparam int AW = 25;
  localparam int DW = 32;
  localparam int WL = 4;
  localparam int TO = 20;
  localparam int EW = 56;

  localparam logic [3:0] K_ACK = 4'd1;
  localparam logic [3:0] K_RV  = 4'd2;
  localparam logic [3:0] K_WV  = 4'd3;
  localparam logic [3:0] K_ERR = 4'd4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;

  sdram_port_arbiter_if #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WORD_LEN(WL)) bus();

  sdram_port_arbiter #(
    .NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WORD_LEN(WL), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  function automatic logic [EW-1:0] ev(input int c, input logic [3:0] k, input int p, input logic [31:0] d);
    logic [15:0] cs;
    logic [3:0]  ps;
    cs = c[15:0];
    ps = p[3:0];
    return {cs, k, ps, d};
  endfunction

  // ---------------- monitor / scoreboard ----------------
  logic        prev_cmd = 1'b0;
  logic        prev_rdy = 1'b0;
  logic [29:0] prev_val = '0;
  logic        cur_cmd;
  logic [29:0] cur_val;

  task automatic got_ev(input logic [EW-1:0] e, input string nm);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_%s: got %0h expected none", nm, e);
    end else begin
      check(nm, 64'(e), 64'(exp_q.pop_front()));
    end
  endtask

  always @(negedge clk) begin
    cur_cmd = bus.m_rd | (|bus.m_wr);
    cur_val = {bus.m_rd, bus.m_wr, bus.m_addr};
    if (rst) begin
      prev_cmd = 1'b0;
    end else begin
      if (prev_cmd && !prev_rdy) check("held_cmd", 64'(cur_val), 64'(prev_val));
      if (prev_cmd && prev_rdy)  check("cmd_drop", 64'(cur_cmd), 64'(0));
      for (int i = 0; i < NP; i++) begin
        if (bus.p_ack[i])    got_ev(ev(cyc, K_ACK, i, {2'b00, cur_val}), "ack");
        if (bus.p_rvalid[i]) got_ev(ev(cyc, K_RV, i, bus.p_rdata), "rvalid");
        if (bus.p_wvalid[i]) got_ev(ev(cyc, K_WV, i, 32'h0), "wvalid");
        if (bus.p_err[i])    got_ev(ev(cyc, K_ERR, i, 32'h0), "err");
      end
      prev_cmd = cur_cmd;
    end
    prev_rdy = bus.m_rdy;
    prev_val = cur_val;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic rd, input logic [3:0] be,
                         input logic [24:0] a, input logic [31:0] d);
    bus.p_rd[p]              = rd;
    bus.p_wr[p*WL +: WL]     = be;
    bus.p_addr[p*AW +: AW]   = a;
    bus.p_wdata[p*DW +: DW]  = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_ack",   64'(bus.p_ack), 64'(0));
    check("rst_cpl",   64'({bus.p_rvalid, bus.p_wvalid, bus.p_err}), 64'(0));
    check("rst_mcmd",  64'({bus.m_rd, bus.m_wr}), 64'(0));
    check("rst_maddr", 64'(bus.m_addr), 64'(0));
    check("rst_mwdat", 64'(bus.m_wdata), 64'(0));
    check("rst_state", 64'(dbg_state), 64'(0));
  endtask

  // Called in an IDLE cycle. done_at = cycles after ack for completion, 0 = never.
  task automatic do_txn(input int p, input logic rd, input logic [3:0] be, input logic [24:0] a,
                        input logic [31:0] wd, input int stall, input int done_at, input logic [31:0] rdat);
    logic [29:0] cmd;
    int ack_c;
    cmd = {rd, (rd ? 4'h0 : be), a};
    set_req(p, rd, be, a, wd);
    tick();
    if (stall > 0) begin
      bus.m_rdy = 1'b0;
      repeat (stall) tick();
    end
    bus.m_rdy = 1'b1;
    ack_c = cyc;
    exp_q.push_back(ev(ack_c, K_ACK, p, {2'b00, cmd}));
    tick();
    set_req(p, 1'b0, 4'h0, 25'h0, 32'h0);
    if (done_at > 0) begin
      repeat (done_at - 1) tick();
      if (rd) begin
        bus.m_rvalid = 1'b1;
        bus.m_rdata  = rdat;
        exp_q.push_back(ev(cyc, K_RV, p, rdat));
      end else begin
        bus.m_wvalid = 1'b1;
        exp_q.push_back(ev(cyc, K_WV, p, 32'h0));
      end
      tick();
      bus.m_rvalid = 1'b0;
      bus.m_wvalid = 1'b0;
    end else begin
      exp_q.push_back(ev(ack_c + TO, K_ERR, p, 32'h0));
      repeat (TO - 1) tick();
      tick();
      check("idle_after_timeout", 64'(dbg_state), 64'(0));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.p_rd     = '0;
    bus.p_wr     = '0;
    bus.p_addr   = '0;
    bus.p_wdata  = '0;
    bus.m_rdy    = 1'b1;
    bus.m_rdata  = '0;
    bus.m_rvalid = 1'b0;
    bus.m_wvalid = 1'b0;
    do_reset();

    // single port read
    do_txn(1, 1'b1, 4'h0, 25'h0000100, 32'h0, 0, 4, 32'hDEADBEEF);

    // rd+wr conflict is a read
    do_txn(0, 1'b1, 4'h3, 25'h0000200, 32'h11223344, 0, 2, 32'h12345678);

    // spurious completions while idle
    bus.m_wvalid = 1'b1;
    bus.m_rvalid = 1'b1;
    @(negedge clk);
    check("spurious_idle", 64'({bus.p_rvalid, bus.p_wvalid}), 64'(0));
    tick();
    bus.m_wvalid = 1'b0;
    bus.m_rvalid = 1'b0;

    // backpressure
    do_txn(2, 1'b0, 4'hF, 25'h1ABCDEF, 32'hCAFEF00D, 10, 3, 32'h0);

    // timeout, then normal service, then completion on the expiry cycle
    do_txn(3, 1'b1, 4'h0, 25'h0000055, 32'h0, 0, 0, 32'h0);
    do_txn(1, 1'b0, 4'h5, 25'h0000300, 32'h0BADCAFE, 0, 5, 32'h0);
    do_txn(0, 1'b1, 4'h0, 25'h0000400, 32'h0, 0, TO, 32'hA5A5A5A5);

    // fairness with four continuous writers
    do_reset();
    for (int p = 0; p < NP; p++) set_req(p, 1'b0, 4'hF, 25'(32'h1000 + p), 32'(p) * 32'h11111111);
    for (int n = 0; n < 6; n++) begin
      tick();
      exp_q.push_back(ev(cyc, K_ACK, n % NP, {2'b00, 1'b0, 4'hF, 25'(32'h1000 + (n % NP))}));
      tick();
      tick();
      tick();
      bus.m_wvalid = 1'b1;
      exp_q.push_back(ev(cyc, K_WV, n % NP, 32'h0));
      tick();
      bus.m_wvalid = 1'b0;
    end
    for (int p = 0; p < NP; p++) set_req(p, 1'b0, 4'h0, 25'h0, 32'h0);

    // reset in WAIT drops the transaction and restores port 0 priority
    do_txn(0, 1'b0, 4'h1, 25'h0000500, 32'h55, 0, 2, 32'h0);
    set_req(2, 1'b1, 4'h0, 25'h0000077, 32'h0);
    tick();
    exp_q.push_back(ev(cyc, K_ACK, 2, {2'b00, 1'b1, 4'h0, 25'h0000077}));
    tick();
    set_req(2, 1'b0, 4'h0, 25'h0, 32'h0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.m_rvalid = 1'b1;
    bus.m_rdata  = 32'h00000BAD;
    @(negedge clk);
    check("post_rst_rvalid", 64'(bus.p_rvalid), 64'(0));
    check("post_rst_pulses", 64'({bus.p_ack, bus.p_wvalid, bus.p_err}), 64'(0));
    check("post_rst_mcmd",   64'({bus.m_rd, bus.m_wr}), 64'(0));
    check("post_rst_maddr",  64'(bus.m_addr), 64'(0));
    check("post_rst_state",  64'(dbg_state), 64'(0));
    tick();
    bus.m_rvalid = 1'b0;
    set_req(1, 1'b1, 4'h0, 25'h0000601, 32'h0);
    do_txn(0, 1'b1, 4'h0, 25'h0000600, 32'h0, 0, 3, 32'h01020304);
    do_txn(1, 1'b1, 4'h0, 25'h0000601, 32'h0, 0, 2, 32'h05060708);

    tick();
    tick();
    check("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
